// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, widths and hazard FSM states.
package pipe_pkg;

    localparam int unsigned WB_W      = 2;
    localparam int unsigned M_W       = 3;
    localparam int unsigned EXE_W     = 4;
    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned WAIT_W    = 8;
    localparam int unsigned PERF_W    = 32;

    localparam int unsigned WB_REGWRITE  = 0;
    localparam int unsigned WB_MEMTOREG  = 1;
    localparam int unsigned M_BRANCH     = 0;
    localparam int unsigned M_MEMREAD    = 1;
    localparam int unsigned M_MEMWRITE   = 2;
    localparam int unsigned EXE_REGDST   = 0;
    localparam int unsigned EXE_ALUOP_LO = 1;
    localparam int unsigned EXE_ALUOP_HI = 2;
    localparam int unsigned EXE_ALUSRC   = 3;

    localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;
    localparam logic [WAIT_W-1:0]    WAIT_SAT = '1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use dependence detector; mask suppresses detection while IF/ID holds a flushed NOP.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             mask,
    output logic             lu_c
);

    // $zero as a load target never creates a true dependence
    always_comb begin
        lu_c = idex_memread & ~mask
             & (idex_rt != REG_W'(REG_ZERO))
             & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, memory freeze with watchdog.
// Define HAZARD_PERF_EN to add stall/flush/freeze event counters and their ports.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WB_W-1:0]  ctrl_wb_in,
    input  logic [M_W-1:0]   ctrl_m_in,
    input  logic [EXE_W-1:0] ctrl_exe_in,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_memread,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memacc,
    input  logic             mem_ready,
    output logic [WB_W-1:0]  ctrl_wb_out,
    output logic [M_W-1:0]   ctrl_m_out,
    output logic [EXE_W-1:0] ctrl_exe_out,
    output logic             pc_en,
    output logic             pc_src,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_en,
    output logic             wdog_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] freeze_cnt
`endif
);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              freeze;
    logic              taken;
    logic              lu;

    always_comb begin
        freeze = exmem_memacc & ~mem_ready;
        taken  = exmem_branch & exmem_zero;
    end

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .mask         (state == FLUSH),
        .lu_c         (lu)
    );

    // Next state and zero-latency pipeline controls, priority freeze > taken > lu
    always_comb begin
        state_nxt    = RUN;
        wait_nxt     = '0;
        ctrl_wb_out  = ctrl_wb_in;
        ctrl_m_out   = ctrl_m_in;
        ctrl_exe_out = ctrl_exe_in;
        pc_en        = 1'b1;
        pc_src       = 1'b0;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pipe_en      = 1'b1;

        if (rst) begin
            ctrl_wb_out  = '0;
            ctrl_m_out   = '0;
            ctrl_exe_out = '0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            pipe_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
        end else if (freeze) begin
            state_nxt = FREEZE;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            pipe_en   = 1'b0;
            // The entry cycle is not counted; only cycles already in FREEZE are
            if (state == FREEZE) begin
                wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + WAIT_W'(1);
            end else begin
                wait_nxt = wait_cnt;
            end
        end else if (taken) begin
            state_nxt    = FLUSH;
            ctrl_wb_out  = '0;
            ctrl_m_out   = '0;
            ctrl_exe_out = '0;
            pc_src       = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
        end else if (lu) begin
            state_nxt    = STALL;
            ctrl_wb_out  = '0;
            ctrl_m_out   = '0;
            ctrl_exe_out = '0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
        end
    end

    // Watchdog is sticky until reset; the pipeline keeps waiting regardless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (wait_nxt >= WAIT_W'(MAX_WAIT)) begin
                wdog_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_cyc;
    logic flush_cyc;

    always_comb begin
        stall_cyc = ~freeze & ~taken & lu;
        flush_cyc = ~freeze & taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            stall_cnt  <= stall_cnt + PERF_W'(stall_cyc);
            flush_cnt  <= flush_cnt + PERF_W'(flush_cyc);
            freeze_cnt <= freeze_cnt + PERF_W'(freeze);
        end
    end
`endif

endmodule
